modsq_iter_ctrl: RTL

//  Single-clock, parametrised successor to the modular-squaring IO wrapper. Accepts one

---
 rtl/modsq_iter_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/modsq_iter_ctrl.sv
// Iteration controller for the modular-squaring core: takes one operand, runs the core T times
// and returns the T-th result, with backpressure, abort and a T=0 bypass.
module modsq_iter_ctrl #(
    parameter int unsigned MOD_LEN            = 1024,
    parameter int unsigned WORD_LEN           = 16,
    parameter int unsigned BIT_LEN            = 17,
    parameter int unsigned REDUNDANT_ELEMENTS = 2,
    parameter int unsigned IN_STAGES          = 3,
    parameter int unsigned OUT_STAGES         = 3,
    parameter int unsigned ITER_W             = 64,
    localparam int unsigned NUM_ELEMENTS = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    localparam int unsigned SQ_OUT_BITS  = NUM_ELEMENTS * 2 * WORD_LEN,
    localparam int unsigned CORE_W       = NUM_ELEMENTS * BIT_LEN
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MOD_LEN-1:0]     sq_in,
    input  logic [ITER_W-1:0]      iter_count,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SQ_OUT_BITS-1:0] sq_out,
    output logic [ITER_W-1:0]      out_iters,
    output logic                   busy,
    output logic                   core_start,
    output logic                   core_halt,
    output logic [CORE_W-1:0]      core_sq_in,
    input  logic [CORE_W-1:0]      core_sq_out,
    input  logic                   core_valid
);

    localparam int unsigned NONRED = MOD_LEN / WORD_LEN;
    localparam int unsigned LCW    = (IN_STAGES > 1) ? $clog2(IN_STAGES) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StHold} state_e;

    state_e                 state_q, state_d;
    logic [ITER_W-1:0]      t_q, t_d, cnt_q, cnt_d, out_iters_q, out_iters_d, cnt_inc;
    logic [LCW-1:0]         load_cnt_q, load_cnt_d;
    logic                   abort_q, abort_d;
    logic [SQ_OUT_BITS-1:0] sq_out_q, sq_out_d;
    logic [CORE_W-1:0]      in_elems;
    logic [CORE_W-1:0]      in_pipe_q [IN_STAGES];
    logic [CORE_W-1:0]      dq_pipe_q [OUT_STAGES];
    logic [OUT_STAGES-1:0]  dv_pipe_q;
    logic                   accept, dv;
    logic [CORE_W-1:0]      dq;

    // Zero-extend each BIT_LEN core coefficient into a 2*WORD_LEN output slot.
    function automatic logic [SQ_OUT_BITS-1:0] widen(input logic [CORE_W-1:0] c);
        logic [SQ_OUT_BITS-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < NUM_ELEMENTS; j++) begin
            r[j*2*WORD_LEN +: BIT_LEN] = c[j*BIT_LEN +: BIT_LEN];
        end
        return r;
    endfunction

    always_comb begin
        in_elems = '0;
        for (int unsigned j = 0; j < NONRED; j++) begin
            in_elems[j*BIT_LEN +: WORD_LEN] = sq_in[j*WORD_LEN +: WORD_LEN];
        end
    end

    // Stage 0 only changes on accept, so the whole pipe settles on the operand.
    always_ff @(posedge clk) begin
        if (accept) in_pipe_q[0] <= in_elems;
        for (int unsigned i = 1; i < IN_STAGES; i++) in_pipe_q[i] <= in_pipe_q[i-1];
        dq_pipe_q[0] <= core_sq_out;
        for (int unsigned i = 1; i < OUT_STAGES; i++) dq_pipe_q[i] <= dq_pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dv_pipe_q <= '0;
        end else begin
            dv_pipe_q[0] <= core_valid;
            for (int unsigned i = 1; i < OUT_STAGES; i++) dv_pipe_q[i] <= dv_pipe_q[i-1];
        end
    end

    assign dv      = dv_pipe_q[OUT_STAGES-1];
    assign dq      = dq_pipe_q[OUT_STAGES-1];
    assign accept  = in_valid && (state_q == StIdle);
    assign cnt_inc = cnt_q + ITER_W'(1);

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        cnt_d       = cnt_q;
        load_cnt_d  = load_cnt_q;
        abort_d     = abort_q;
        sq_out_d    = sq_out_q;
        out_iters_d = out_iters_q;
        core_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    t_d        = iter_count;
                    load_cnt_d = '0;
                    abort_d    = 1'b0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (load_cnt_q == LCW'(IN_STAGES - 1)) begin
                    if (t_q != '0) begin
                        core_start = 1'b1;
                        cnt_d      = '0;
                        state_d    = StRun;
                    end else begin
                        sq_out_d    = widen(core_sq_in);
                        out_iters_d = '0;
                        state_d     = StHold;
                    end
                end else begin
                    load_cnt_d = load_cnt_q + LCW'(1);
                end
            end
            StRun: begin
                if (abort) abort_d = 1'b1;
                if (dv) begin
                    cnt_d = cnt_inc;
                    // A pending abort ends the job on the next completed iteration.
                    if (cnt_inc == t_q || abort || abort_q) begin
                        sq_out_d    = widen(dq);
                        out_iters_d = cnt_inc;
                        state_d     = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            t_q         <= '0;
            cnt_q       <= '0;
            load_cnt_q  <= '0;
            abort_q     <= 1'b0;
            sq_out_q    <= '0;
            out_iters_q <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            cnt_q       <= cnt_d;
            load_cnt_q  <= load_cnt_d;
            abort_q     <= abort_d;
            sq_out_q    <= sq_out_d;
            out_iters_q <= out_iters_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign out_valid  = (state_q == StHold);
    assign core_halt  = (state_q != StRun);
    assign core_sq_in = in_pipe_q[IN_STAGES-1];
    assign sq_out     = sq_out_q;
    assign out_iters  = out_iters_q;

endmodule
